td4_clock_gen: RTL and testbench

//  Upstream timing stage for the TD4 core. Turns the 50 MHz board clock into a

---
 rtl/td4_clock_gen_pkg.sv | 33 +++
 rtl/td4_clock_gen_if.sv | 38 +++
 rtl/td4_clock_gen_debounce.sv | 103 ++++++++++
 rtl/td4_clock_gen.sv | 90 +++++++++
 tb/tb_td4_clock_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/td4_clock_gen_pkg.sv
// ----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 clock generator slice.
//  - Default divider ratios for the 50 MHz board clock (1 Hz slow, 10 Hz fast)
//  - Default debounce window for the single-step push button (20 ms)
//  - Divider counter width default
//  - step_state_t : states of the single-step button FSM
// ----------------------------------------------------------------------------
package td4_pkg;

   localparam int unsigned TD4_DIV_SLOW  = 50_000_000;
   localparam int unsigned TD4_DIV_FAST  = 5_000_000;
   localparam int unsigned TD4_DB_CYCLES = 1_000_000;
   localparam int unsigned TD4_CNT_W     = 27;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } step_state_t;

   // Width of a counter able to hold the values 0 .. maxValue (at least 1 bit).
   function automatic int unsigned countWidth(input int unsigned maxValue);
      int unsigned w;
      w = 1;
      while ((w < 32) && ((64'd1 << w) <= 64'(maxValue))) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/td4_clock_gen_if.sv
// ----------------------------------------------------------------------------
// td4_clock_gen_if
// Control/status bundle between the board-level controls and the TD4 timing
// stage.
//  run       1 = free-run, 0 = halted
//  sel_fast  1 = fast step rate, 0 = slow step rate
//  step_btn  raw asynchronous single-step push button, active-high
//  tick      one-clock-wide CPU step enable
//  tick_cnt  number of ticks issued, modulo 256
// Modports:
//  master : drives the controls, observes tick/tick_cnt (board / testbench)
//  slave  : the clock generator itself
// ----------------------------------------------------------------------------
interface td4_clock_gen_if;

   logic       run;
   logic       sel_fast;
   logic       step_btn;
   logic       tick;
   logic [7:0] tick_cnt;

   modport master (
      output run,
      output sel_fast,
      output step_btn,
      input  tick,
      input  tick_cnt
   );

   modport slave (
      input  run,
      input  sel_fast,
      input  step_btn,
      output tick,
      output tick_cnt
   );

endinterface

// File: rtl/td4_clock_gen_debounce.sv
// ----------------------------------------------------------------------------
// td4_debounce
// Single-step push-button conditioner: a 2-flop synchronizer followed by a
// four-state debounce FSM. A level change is accepted only after the
// synchronized button has held the new level for DB_CYCLES consecutive clocks.
// Ports:
//  clk        board clock
//  rst        synchronous active-high reset
//  btn_i      raw asynchronous button, active-high
//  pressed_o  one-cycle pulse (combinational) on the clock edge where a press
//             is accepted; registered by the parent
// Only instantiated when TD4_SINGLE_STEP_EN is defined.
// ----------------------------------------------------------------------------
module td4_debounce
   import td4_pkg::*;
#(
   parameter int unsigned DB_CYCLES = TD4_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pressed_o
);

   localparam int unsigned DB_W = countWidth(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam bit SINGLE_SAMPLE = (DB_CYCLES <= 1);

   logic        sync1_q;
   logic        sync2_q;
   step_state_t state_q, state_d;
   logic [DB_W-1:0] count_q, count_d;

   // Synchronizer, FSM state and stable-level counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state logic. count_q holds how many consecutive synchronized samples
   // have shown the new level; the sample that moves IDLE->PRESS (or
   // HELD->RELEASE) is the first of them, so the counter starts at 1.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pressed_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync2_q) begin
               if (SINGLE_SAMPLE) begin
                  state_d   = HELD;
                  pressed_o = 1'b1;
               end else begin
                  state_d = PRESS;
                  count_d = DB_W'(1);
               end
            end
         end
         PRESS: begin
            if (!sync2_q) begin
               state_d = IDLE;
            end else if (count_q == DB_LAST) begin
               state_d   = HELD;
               pressed_o = 1'b1;
            end else begin
               count_d = count_q + DB_W'(1);
            end
         end
         HELD: begin
            if (!sync2_q) begin
               if (SINGLE_SAMPLE) begin
                  state_d = IDLE;
               end else begin
                  state_d = RELEASE;
                  count_d = DB_W'(1);
               end
            end
         end
         RELEASE: begin
            if (sync2_q) begin
               state_d = HELD;
            end else if (count_q == DB_LAST) begin
               state_d = IDLE;
            end else begin
               count_d = count_q + DB_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/td4_clock_gen.sv
// ----------------------------------------------------------------------------
// td4_clock_gen
// Upstream timing stage for the TD4 core. Divides the board clock into a
// one-cycle CPU step enable 'tick' (slow or fast rate), supports halt, and
// keeps a wrapping 8-bit count of issued ticks.
// Ports:
//  clk   board clock
//  rst   synchronous active-high reset
//  bus   td4_clock_gen_if.slave : run, sel_fast, step_btn in; tick, tick_cnt out
// Configuration:
//  TD4_SINGLE_STEP_EN  when defined, step_btn is debounced (td4_debounce) and
//                      each accepted press issues one tick while halted. When
//                      undefined, step_btn is ignored and run=0 is a hard halt.
// ----------------------------------------------------------------------------
module td4_clock_gen
   import td4_pkg::*;
#(
   parameter int unsigned DIV_SLOW  = TD4_DIV_SLOW,
   parameter int unsigned DIV_FAST  = TD4_DIV_FAST,
   parameter int unsigned DB_CYCLES = TD4_DB_CYCLES,
   parameter int unsigned CNT_W     = TD4_CNT_W
) (
   input logic            clk,
   input logic            rst,
   td4_clock_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] LIMIT_SLOW = CNT_W'(DIV_SLOW - 1);
   localparam logic [CNT_W-1:0] LIMIT_FAST = CNT_W'(DIV_FAST - 1);

   logic [CNT_W-1:0] divCnt_q, divCnt_d;
   logic [CNT_W-1:0] divLimit;
   logic             divFire;
   logic             tick_q, tick_d;
   logic [7:0]       tickCnt_q, tickCnt_d;
   logic             stepPulse;

`ifdef TD4_SINGLE_STEP_EN
   logic stepPressed;

   td4_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (bus.step_btn),
      .pressed_o (stepPressed)
   );

   // Presses are always tracked, but only step the CPU while halted.
   assign stepPulse = stepPressed && !bus.run;
`else
   localparam int unsigned unusedDbCycles = DB_CYCLES;
   logic unusedStepBtn;

   assign unusedStepBtn = bus.step_btn;
   assign stepPulse     = 1'b0;
`endif

   // Divider: the >= compare lets a mid-count switch to a shorter period fire
   // on the very next edge. Halting parks the counter at 0 so resuming always
   // starts a full period.
   always_comb begin
      divLimit  = bus.sel_fast ? LIMIT_FAST : LIMIT_SLOW;
      divFire   = bus.run && (divCnt_q >= divLimit);
      divCnt_d  = divCnt_q + CNT_W'(1);
      if (!bus.run || divFire) begin
         divCnt_d = '0;
      end
      tick_d    = divFire || stepPulse;
      tickCnt_d = tickCnt_q + 8'(tick_d);
   end

   // Registered tick and its counter update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt_q  <= '0;
         tick_q    <= 1'b0;
         tickCnt_q <= '0;
      end else begin
         divCnt_q  <= divCnt_d;
         tick_q    <= tick_d;
         tickCnt_q <= tickCnt_d;
      end
   end

   assign bus.tick     = tick_q;
   assign bus.tick_cnt = tickCnt_q;

endmodule

// File: tb/tb_td4_clock_gen.sv
// ----------------------------------------------------------------------------
// tb_td4_clock_gen
// Self-checking bench for td4_clock_gen with DIV_SLOW=10, DIV_FAST=4,
// DB_CYCLES=3. A period/level-based reference model predicts tick and
// tick_cnt every cycle; directed sections pin the model with literal values.
// Single-step sections are built only when TD4_SINGLE_STEP_EN is defined.
// ----------------------------------------------------------------------------
module tb_td4_clock_gen;
   import td4_pkg::*;

   localparam int DIV_SLOW_T = 10;
   localparam int DIV_FAST_T = 4;
   localparam int DB_T       = 3;

   logic clk = 1'b0;
   logic rst;

   td4_clock_gen_if bus ();

   td4_clock_gen #(
      .DIV_SLOW  (DIV_SLOW_T),
      .DIV_FAST  (DIV_FAST_T),
      .DB_CYCLES (DB_T),
      .CNT_W     (27)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks      = 0;
   int failures    = 0;
   bit checkEnable = 1'b0;

   // Reference model state.
   int mEdges  = 0;
   bit mTick   = 1'b0;
   int mCnt    = 0;
`ifdef TD4_SINGLE_STEP_EN
   bit mHist0    = 1'b0;
   bit mHist1    = 1'b0;
   bit mAccepted = 1'b0;
   int mStreak   = 0;
   bit mSample;
`endif

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit runV, input bit fastV, input bit btnV);
      bus.run      = runV;
      bus.sel_fast = fastV;
      bus.step_btn = btnV;
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model: a tick is due once the current run period has lasted
   // DIV_sel edges; halting abandons the period. The button is seen two edges
   // late and its accepted level flips after DB_T consecutive opposite samples.
   always @(posedge clk) begin
      if (rst) begin
         mEdges = 0;
         mTick  = 1'b0;
         mCnt   = 0;
`ifdef TD4_SINGLE_STEP_EN
         mHist0    = 1'b0;
         mHist1    = 1'b0;
         mAccepted = 1'b0;
         mStreak   = 0;
`endif
      end else begin
         mTick = 1'b0;
         if (bus.run) begin
            mEdges++;
            if (mEdges >= (bus.sel_fast ? DIV_FAST_T : DIV_SLOW_T)) begin
               mTick  = 1'b1;
               mEdges = 0;
            end
         end else begin
            mEdges = 0;
         end
`ifdef TD4_SINGLE_STEP_EN
         mSample = mHist1;
         mHist1  = mHist0;
         mHist0  = bus.step_btn;
         if (mSample != mAccepted) begin
            mStreak++;
            if (mStreak >= DB_T) begin
               mAccepted = mSample;
               mStreak   = 0;
               if (mSample && !bus.run) mTick = 1'b1;
            end
         end else begin
            mStreak = 0;
         end
`endif
         if (mTick) mCnt = (mCnt + 1) % 256;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput("modelTick", bus.tick, mTick);
         checkOutput("modelTickCnt", bus.tick_cnt, mCnt);
      end
   end

   // Watchdog: the bench must never hang.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ticksSeen;
      int budget;

      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset();
      checkEnable = 1'b1;
      checkOutput("rstTick", bus.tick, 0);
      checkOutput("rstTickCnt", bus.tick_cnt, 0);

      // Free-run slow: ticks at cycles 10, 20, 30.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 37; c++) begin
         @(negedge clk);
         if (c <= 31) checkOutput("slowTick", bus.tick, (c == 10 || c == 20 || c == 30) ? 1 : 0);
         if (c == 31) checkOutput("slowTickCnt31", bus.tick_cnt, 3);
      end

      // Counter now at 7: switching to fast fires on the next edge.
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int c = 38; c <= 46; c++) begin
         @(negedge clk);
         checkOutput("fastSwitchTick", bus.tick, (c == 38 || c == 42 || c == 46) ? 1 : 0);
      end
      checkOutput("fastSwitchTickCnt", bus.tick_cnt, 6);

      // Halt for 50 cycles, then resume slow: full period before next tick.
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         checkOutput("haltTick", bus.tick, 0);
      end
      checkOutput("haltTickCnt", bus.tick_cnt, 6);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checkOutput("resumeTick", bus.tick, (i == 10) ? 1 : 0);
      end

`ifdef TD4_SINGLE_STEP_EN
      // Clean press while halted: one tick, 5 cycles after the rise.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         checkOutput("cleanPressTick", bus.tick, (i == 5) ? 1 : 0);
      end
      checkOutput("cleanPressTickCnt", bus.tick_cnt, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);

      // Bouncing press 1,0,1 then stable: one tick, 5 cycles after last rise.
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         checkOutput("bouncePressTick", bus.tick, (i == 5) ? 1 : 0);
      end
      checkOutput("bouncePressTickCnt", bus.tick_cnt, 2);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);

      // Press while running is tracked but gives no extra tick.
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (12) @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
`endif

      // 300 fast ticks: tick_cnt must wrap through 255 -> 0.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      ticksSeen = 0;
      budget    = 0;
      while (ticksSeen < 300 && budget < 2000) begin
         @(negedge clk);
         budget++;
         if (bus.tick === 1'b1) begin
            ticksSeen++;
            checkOutput("wrapTickCnt", bus.tick_cnt, ticksSeen % 256);
         end
      end
      checkOutput("wrapTicksSeen", ticksSeen, 300);
      checkOutput("wrapTickCnt300", bus.tick_cnt, 44);

      // Reset asserted while the button FSM is counting a press.
`ifdef TD4_SINGLE_STEP_EN
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("inPressState", 32'(dut.u_debounce.state_q), 32'(PRESS));
`endif
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("midRstTick", bus.tick, 0);
      checkOutput("midRstTickCnt", bus.tick_cnt, 0);
`ifdef TD4_SINGLE_STEP_EN
      checkOutput("midRstFsmIdle", 32'(dut.u_debounce.state_q), 32'(IDLE));
`endif
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRstNoTick", bus.tick, 0);

      // Randomized phase, checked by the model every cycle.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(199) == 0) bus.run = ~bus.run;
         if ($urandom_range(99) == 0) bus.sel_fast = ~bus.sel_fast;
         if ($urandom_range(14) == 0) bus.step_btn = ~bus.step_btn;
         rst = ($urandom_range(999) == 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
